// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage controller and muldiv_unit.
// master drives the request side, slave returns status, results and flags.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, flag_n, flag_z, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, flag_n, flag_z, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MULDIV_EARLY_EXIT_EN to end multiplies once the remaining multiplier is zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [3:0]         op_reg;
  logic               neg_reg;
  // Multiply: acc = partial product, mcand = shifted multiplicand, mplier = remaining multiplier.
  // Divide:   acc[WIDTH-1:0] = remainder, mcand[WIDTH-1:0] = divisor, mplier = dividend/quotient.
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;

  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic               n_reg;
  logic               z_reg;
  logic               dbz_reg;

  logic               legal_next;
  logic [WIDTH-1:0]   a_mag_next;
  logic [WIDTH-1:0]   b_mag_next;
  logic [WIDTH:0]     rem_shift_next;
  logic [WIDTH:0]     trial_next;
  logic [2*WIDTH-1:0] product_next;
  logic               last_next;

  always_comb begin
    legal_next     = (bus.op[3:2] == 2'b01);
    a_mag_next     = (bus.op == OP_SMULL && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag_next     = (bus.op == OP_SMULL && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    rem_shift_next = {acc_reg[WIDTH-1:0], mplier_reg[WIDTH-1]};
    // A set top bit means the trial subtraction borrowed: divisor did not fit.
    trial_next     = rem_shift_next - {1'b0, mcand_reg[WIDTH-1:0]};
    product_next   = neg_reg ? -acc_reg : acc_reg;
    last_next      = (count_reg == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_EXIT_EN
    if (op_reg != OP_DIV && mplier_reg[WIDTH-1:1] == '0)
      last_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && legal_next) begin
            op_reg    <= bus.op;
            count_reg <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
            dbz_reg   <= 1'b0;
            if (bus.op == OP_DIV && bus.b == '0) begin
              lo_reg    <= '1;
              hi_reg    <= bus.a;
              n_reg     <= 1'b1;
              z_reg     <= 1'b0;
              dbz_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              neg_reg   <= (bus.op == OP_SMULL) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              if (bus.op == OP_DIV) begin
                mplier_reg <= bus.a;
                mcand_reg  <= {{WIDTH{1'b0}}, bus.b};
              end else begin
                mplier_reg <= b_mag_next;
                mcand_reg  <= {{WIDTH{1'b0}}, a_mag_next};
              end
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          if (op_reg == OP_DIV) begin
            acc_reg    <= {{WIDTH{1'b0}},
                           trial_next[WIDTH] ? rem_shift_next[WIDTH-1:0] : trial_next[WIDTH-1:0]};
            mplier_reg <= {mplier_reg[WIDTH-2:0], ~trial_next[WIDTH]};
          end else begin
            if (mplier_reg[0])
              acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
          end
          count_reg <= count_reg + 1'b1;
          if (last_next)
            state_reg <= FIX;
        end

        FIX: begin
          case (op_reg)
            OP_MUL: begin
              lo_reg <= acc_reg[WIDTH-1:0];
              hi_reg <= '0;
              n_reg  <= acc_reg[WIDTH-1];
              z_reg  <= (acc_reg[WIDTH-1:0] == '0);
            end
            OP_DIV: begin
              lo_reg <= mplier_reg;
              hi_reg <= acc_reg[WIDTH-1:0];
              n_reg  <= mplier_reg[WIDTH-1];
              z_reg  <= (mplier_reg == '0);
            end
            default: begin
              lo_reg <= product_next[WIDTH-1:0];
              hi_reg <= product_next[2*WIDTH-1:WIDTH];
              n_reg  <= product_next[2*WIDTH-1];
              z_reg  <= (product_next == '0);
            end
          endcase
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end

        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.result_lo   = lo_reg;
  assign bus.result_hi   = hi_reg;
  assign bus.flag_n      = n_reg;
  assign bus.flag_z      = z_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result table plus handshake corner sequences.
module tb_muldiv_unit;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;
  localparam int         NV       = 14;
  localparam int         LIMIT    = 60;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
    logic        dbz;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[NV];

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    logic [31:0] m;
    int          k;
    if (op == OP_DIV) return (b == 32'd0) ? 1 : 34;
    m = (op == OP_SMULL && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MULDIV_EARLY_EXIT_EN
    return k + 2;
`else
    return (k > 0) ? 34 : 34;
`endif
  endfunction

  // Drives start for cycle 0; returns positioned in cycle 1.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int errs;
    int dones;
    int done_cyc;

    vecs[0]  = '{OP_MUL,   32'd7,        32'd6,        32'd42,       32'd0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_SMULL, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_DIV,   32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_DIV,   32'd55,       32'd0,        32'hFFFFFFFF, 32'd55,       1'b1, 1'b0, 1'b1};
    vecs[5]  = '{OP_MUL,   32'd0,        32'd9,        32'd0,        32'd0,        1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_SMULL, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 32'd0,        1'b0, 1'b1, 1'b0};
    vecs[8]  = '{OP_SMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_SMULL, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{OP_DIV,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[11] = '{OP_DIV,   32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_UMULL, 32'h80000000, 32'd2,        32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_SMULL, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.flag_n, bus.flag_z, bus.div_by_zero,
                          bus.result_lo, bus.result_hi}, 64'd0);
    reset = 1'b1;

    // Busy profile for MUL 7*6: high and no done through the cycle before done.
    issue(OP_MUL, 32'd7, 32'd6);
    errs = 0;
    lat  = 1;
    while (lat < exp_lat(OP_MUL, 32'd6)) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) errs++;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_profile_errs", 64'(errs), 64'd0);
    chk("busy_profile_done", {63'd0, bus.done}, 64'd1);
    @(posedge clk); #1;
    chk("busy_after_done", {62'd0, bus.busy, bus.done}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      // Scramble inputs while busy; latched operands must be used.
      bus.op = OP_DIV;
      bus.a  = $urandom;
      bus.b  = 32'd0;
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      chk($sformatf("v%0d_lo", i), {32'd0, bus.result_lo}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_hi", i), {32'd0, bus.result_hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_flags", i), {61'd0, bus.flag_n, bus.flag_z, bus.div_by_zero},
          {61'd0, vecs[i].n, vecs[i].z, vecs[i].dbz});
      $display("vec %0d op=%b a=%h b=%h -> hi=%h lo=%h n=%b z=%b dbz=%b latency=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.result_hi, bus.result_lo,
               bus.flag_n, bus.flag_z, bus.div_by_zero, lat);
      @(posedge clk); #1;
    end

    // Illegal op is ignored.
    issue(4'b0010, 32'd3, 32'd3);
    errs = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) errs++;
      @(posedge clk); #1;
    end
    chk("illegal_op_activity", 64'(errs), 64'd0);
    $display("seq illegal op=0010 activity_cycles=%0d", errs);

    // Start during busy is not queued.
    issue(OP_MUL, 32'd3, 32'd4);
    dones    = 0;
    done_cyc = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd0;
      end
      if (c == 11) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        done_cyc = c;
        chk("busy_start_lo", {32'd0, bus.result_lo}, 64'd12);
        chk("busy_start_dbz", {63'd0, bus.div_by_zero}, 64'd0);
      end
      @(posedge clk); #1;
    end
    chk("busy_start_done_count", 64'(dones), 64'd1);
    chk("busy_start_done_cycle", 64'(done_cyc), 64'(exp_lat(OP_MUL, 32'd4)));
    $display("seq start-while-busy dones=%0d done_cycle=%0d", dones, done_cyc);

    // Reset mid-operation abandons it.
    issue(OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midreset_outputs", {bus.busy, bus.done, bus.flag_n, bus.flag_z, bus.div_by_zero,
                             bus.result_lo, bus.result_hi}, 64'd0);
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    chk("midreset_no_done", 64'(dones), 64'd0);
    issue(OP_MUL, 32'd2, 32'd2);
    wait_done(lat);
    chk("post_reset_latency", 64'(lat), 64'(exp_lat(OP_MUL, 32'd2)));
    chk("post_reset_lo", {32'd0, bus.result_lo}, 64'd4);
    $display("seq reset-mid-op then MUL 2*2 lo=%0d latency=%0d", bus.result_lo, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
